// File: rtl/libiu.sv
// Shared definitions for the simdma init path: clock bundle, ROM depth and
// the init-ROM record encoding.
package libiu;

  typedef struct packed {
    logic clk;
  } iu_clk_type;

  localparam int ROM_WORDS_DEFAULT = 8192;

  typedef enum logic [1:0] {
    OP_END   = 2'b00,
    OP_WRITE = 2'b01,
    OP_FILL  = 2'b10,
    OP_RSVD  = 2'b11
  } iu_op_e;

  // Header word layout; bits between the op and count fields are don't-care.
  localparam int HDR_OP_HI  = 31;
  localparam int HDR_OP_LO  = 30;
  localparam int HDR_CNT_HI = 13;
  localparam int HDR_CNT_LO = 0;
  localparam int HDR_CNT_W  = HDR_CNT_HI - HDR_CNT_LO + 1;

endpackage

// File: rtl/simdma_init_loader.sv
// Walks the init ROM record stream once per start and turns it into word
// writes on a valid/ready port, stopping at END or on the first fault.
//
// state | meaning
// IDLE  | waiting for start, never loaded
// HDR   | rom_dout holds a record header
// DST   | rom_dout holds the destination byte address
// DATA  | rom_dout holds the next WRITE payload word
// FILL  | replaying one FILL word count times
// DRAIN | END seen, waiting for the last write to be accepted
// DONE  | load complete
// ERR   | load aborted
module simdma_init_loader
  import libiu::*;
#(
  parameter int ROM_WORDS = ROM_WORDS_DEFAULT
) (
  input  iu_clk_type  gclk,
  input  logic        rst,
  input  logic        start,
  output logic [15:0] rom_addr,
  input  logic [31:0] rom_dout,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_DST, S_DATA, S_FILL, S_DRAIN, S_DONE, S_ERR
  } state_e;

  localparam logic [15:0]          LAST_PTR = 16'(ROM_WORDS - 1);
  localparam logic [HDR_CNT_W-1:0] CNT_ONE  = HDR_CNT_W'(1);

  logic                 clk;
  state_e               state;
  iu_op_e               op;
  iu_op_e               hdr_op;
  logic [HDR_CNT_W-1:0] cnt;
  logic [31:0]          dst_addr;
  logic [31:0]          fill_data;
  logic                 fill_have;
  logic [15:0]          ptr;
  logic [15:0]          ptr_next;
  logic                 consume;
  logic                 fault;
  logic                 load_ok;
  logic                 last_word;

  assign clk       = gclk.clk;
  assign hdr_op    = iu_op_e'(rom_dout[HDR_OP_HI:HDR_OP_LO]);
  assign load_ok   = !wr_valid || wr_ready;
  assign last_word = (ptr == LAST_PTR);

  // Every consumed word except an END header implies another word is needed,
  // so consuming the last ROM word in those cases is an overrun.
  always_comb begin
    consume = 1'b0;
    fault   = 1'b0;
    case (state)
      S_HDR: begin
        consume = 1'b1;
        fault   = (hdr_op == OP_RSVD) || ((hdr_op != OP_END) && last_word);
      end
      S_DST: begin
        consume = 1'b1;
        fault   = (rom_dout[1:0] != 2'b00) || last_word;
      end
      S_DATA: begin
        consume = load_ok;
        fault   = load_ok && last_word;
      end
      S_FILL: begin
        consume = !fill_have;
        fault   = !fill_have && last_word;
      end
      default: ;
    endcase
  end

  // The ROM sees the post-edge pointer so its data lines up with ptr.
  assign ptr_next = consume ? (ptr + 16'd1) : ptr;
  assign rom_addr = (state == S_IDLE || state == S_DONE || state == S_ERR) ? 16'd0 : ptr_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      op        <= OP_END;
      cnt       <= '0;
      dst_addr  <= '0;
      fill_data <= '0;
      fill_have <= 1'b0;
      ptr       <= '0;
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      ptr <= ptr_next;
      if (wr_valid && wr_ready) wr_valid <= 1'b0;

      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state <= S_HDR;
            ptr   <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
            err   <= 1'b0;
          end
        end
        S_HDR: begin
          op    <= hdr_op;
          cnt   <= rom_dout[HDR_CNT_HI:HDR_CNT_LO];
          state <= (hdr_op == OP_END) ? S_DRAIN : S_DST;
        end
        S_DST: begin
          dst_addr  <= rom_dout;
          fill_have <= 1'b0;
          if (cnt == '0)         state <= S_HDR;
          else if (op == OP_FILL) state <= S_FILL;
          else                   state <= S_DATA;
        end
        S_DATA: begin
          if (load_ok) begin
            wr_valid <= 1'b1;
            wr_addr  <= dst_addr;
            wr_data  <= rom_dout;
            dst_addr <= dst_addr + 32'd4;
            cnt      <= cnt - CNT_ONE;
            if (cnt == CNT_ONE) state <= S_HDR;
          end
        end
        S_FILL: begin
          if (!fill_have) begin
            fill_data <= rom_dout;
            fill_have <= 1'b1;
          end
          if (load_ok) begin
            wr_valid <= 1'b1;
            wr_addr  <= dst_addr;
            wr_data  <= fill_have ? fill_data : rom_dout;
            dst_addr <= dst_addr + 32'd4;
            cnt      <= cnt - CNT_ONE;
            if (cnt == CNT_ONE) state <= S_HDR;
          end
        end
        S_DRAIN: begin
          if (load_ok) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase

      // A fault wins over everything above, including a write loaded this edge.
      if (fault) begin
        state    <= S_ERR;
        err      <= 1'b1;
        busy     <= 1'b0;
        wr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_simdma_init_loader.sv
// Directed bench for simdma_init_loader: a behavioural ROM, a write scoreboard
// fed by the stimulus and drained by a monitor on every accepted write.
module tb_simdma_init_loader;
  import libiu::*;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  iu_clk_type  gclk;
  logic        rst;
  logic        start;
  logic [15:0] rom_addr;
  logic [31:0] rom_dout;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        err;

  logic [31:0] rom [0:8191];
  wr_t         exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          max_addr;
  logic        prev_stall;
  logic [31:0] prev_a;
  logic [31:0] prev_d;

  assign gclk.clk = clk;
  always #5 clk = ~clk;

  simdma_init_loader dut (
    .gclk(gclk), .rst(rst), .start(start), .rom_addr(rom_addr), .rom_dout(rom_dout),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err)
  );

  always @(posedge clk) rom_dout <= rom[rom_addr[12:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: pops one expected write per accepted handshake, and checks the
  // output register holds still across a stall.
  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (busy && rom_addr > max_addr[15:0]) max_addr = int'(rom_addr);
      if (prev_stall && !err) begin
        check("stall_valid", {31'd0, wr_valid}, 32'd1);
        check("stall_addr", wr_addr, prev_a);
        check("stall_data", wr_data, prev_d);
      end
      if (wr_valid && wr_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, none expected", wr_addr, wr_data);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", wr_addr, e.a);
          check("wr_data", wr_data, e.d);
        end
      end
      prev_stall = wr_valid && !wr_ready;
      prev_a     = wr_addr;
      prev_d     = wr_data;
    end
  end

  task automatic clear_rom();
    for (int i = 0; i < 8192; i++) rom[i] = 32'd0;
  endtask

  task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back('{a: a, d: d});
  endtask

  // Leaves the bench 1 time unit after the edge that sampled start.
  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // which: 0 = done, 1 = err. Bounded by budget cycles.
  task automatic wait_for(input int which, input int budget, input bit toggle);
    int cyc;
    cyc = 0;
    while (cyc < budget) begin
      @(negedge clk);
      if ((which == 0 && done) || (which == 1 && err)) break;
      @(posedge clk); #1;
      if (toggle) wr_ready = ~wr_ready;
      cyc++;
    end
    @(negedge clk);
  endtask

  task automatic load_t1();
    clear_rom();
    rom[0] = 32'h4000_0003;
    rom[1] = 32'h0000_1000;
    rom[2] = 32'h1111_AAAA;
    rom[3] = 32'h2222_BBBB;
    rom[4] = 32'h3333_CCCC;
    rom[5] = 32'h0000_0000;
    expect_wr(32'h1000, 32'h1111_AAAA);
    expect_wr(32'h1004, 32'h2222_BBBB);
    expect_wr(32'h1008, 32'h3333_CCCC);
  endtask

  initial begin
    int lat;
    rst = 1'b0; start = 1'b0; wr_ready = 1'b1; prev_stall = 1'b0; max_addr = 0;
    clear_rom();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_rom_addr", {16'd0, rom_addr}, 32'd0);
    check("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
    check("rst_wr_addr", wr_addr, 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_flags", {29'd0, busy, done, err}, 32'd0);

    // WRITE x3 then END, full throughput.
    load_t1();
    pulse_start();
    lat = 0;
    forever begin
      @(negedge clk);
      if (wr_valid || lat > 20) break;
      @(posedge clk);
      lat++;
    end
    check("t1_latency", lat, 3);
    @(negedge clk); check("t1_burst2", {31'd0, wr_valid}, 32'd1);
    @(negedge clk); check("t1_burst3", {31'd0, wr_valid}, 32'd1);
    wait_for(0, 30, 1'b0);
    check("t1_flags", {29'd0, busy, done, err}, 32'b010);
    check("t1_drained", exp_q.size(), 0);

    // FILL x4 with junk in the ignored header bits; ROM pointer must not move during repeats.
    clear_rom();
    rom[0] = 32'hBFFF_C004;
    rom[1] = 32'h0000_2000;
    rom[2] = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) expect_wr(32'h2000 + 32'(4 * i), 32'hDEAD_BEEF);
    max_addr = 0;
    pulse_start();
    wait_for(0, 30, 1'b0);
    check("t2_done", {31'd0, done}, 32'd1);
    check("t2_max_rom_addr", max_addr, 4);

    // WRITE x8 under 1010 backpressure, start pulse while busy, then an address-wrapping record.
    clear_rom();
    rom[0] = 32'h4000_0008;
    rom[1] = 32'h0000_3000;
    for (int i = 0; i < 8; i++) begin
      rom[2 + i] = 32'h3000_0000 + 32'(i);
      expect_wr(32'h3000 + 32'(4 * i), 32'h3000_0000 + 32'(i));
    end
    rom[10] = 32'h4000_0002;
    rom[11] = 32'hFFFF_FFFC;
    rom[12] = 32'h0000_1234;
    rom[13] = 32'h0000_5678;
    expect_wr(32'hFFFF_FFFC, 32'h0000_1234);
    expect_wr(32'h0000_0000, 32'h0000_5678);
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1 wr_ready = ~wr_ready;
    end
    pulse_start();
    wait_for(0, 60, 1'b1);
    wr_ready = 1'b1;
    check("t3_done", {31'd0, done}, 32'd1);
    check("t3_drained", exp_q.size(), 0);

    // Reserved op behind a stalled write: err, write discarded.
    clear_rom();
    rom[0] = 32'h4000_0001;
    rom[1] = 32'h0000_0100;
    rom[2] = 32'h0000_00AB;
    rom[3] = 32'hC000_0001;
    wr_ready = 1'b0;
    pulse_start();
    wait_for(1, 20, 1'b0);
    check("t4a_flags", {29'd0, busy, done, err}, 32'b001);
    check("t4a_wr_valid", {31'd0, wr_valid}, 32'd0);
    wr_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Misaligned destination; start must clear err first.
    clear_rom();
    rom[0] = 32'h4000_0001;
    rom[1] = 32'h0000_1002;
    rom[2] = 32'h0000_0077;
    pulse_start();
    @(negedge clk);
    check("t4b_start_clears", {29'd0, busy, done, err}, 32'b100);
    wait_for(1, 20, 1'b0);
    check("t4b_flags", {29'd0, busy, done, err}, 32'b001);
    check("t4b_wr_valid", {31'd0, wr_valid}, 32'd0);

    // Restart after error reads from word 0 again.
    load_t1();
    pulse_start();
    wait_for(0, 30, 1'b0);
    check("t4c_flags", {29'd0, busy, done, err}, 32'b010);

    // Zero-count record is skipped.
    clear_rom();
    rom[0] = 32'h4000_0000;
    rom[1] = 32'h0000_5000;
    rom[2] = 32'h4000_0001;
    rom[3] = 32'h0000_6000;
    rom[4] = 32'hCAFE_0001;
    expect_wr(32'h6000, 32'hCAFE_0001);
    pulse_start();
    wait_for(0, 30, 1'b0);
    check("t7_done", {31'd0, done}, 32'd1);
    check("t7_drained", exp_q.size(), 0);

    // Asynchronous reset in the middle of a stalled WRITE.
    clear_rom();
    rom[0] = 32'h4000_0006;
    rom[1] = 32'h0000_4000;
    for (int i = 0; i < 6; i++) rom[2 + i] = 32'h4444_0000 + 32'(i);
    wr_ready = 1'b0;
    pulse_start();
    repeat (5) @(posedge clk);
    @(negedge clk); #2 rst = 1'b0;
    #1;
    check("t6_rom_addr", {16'd0, rom_addr}, 32'd0);
    check("t6_wr_valid", {31'd0, wr_valid}, 32'd0);
    check("t6_wr_addr", wr_addr, 32'd0);
    check("t6_wr_data", wr_data, 32'd0);
    check("t6_flags", {29'd0, busy, done, err}, 32'd0);
    repeat (2) @(posedge clk);
    #1 wr_ready = 1'b1;
    @(posedge clk); #1 rst = 1'b1;
    repeat (10) @(negedge clk);
    check("t6_after_busy", {31'd0, busy}, 32'd0);
    check("t6_after_valid", {31'd0, wr_valid}, 32'd0);

    // No END anywhere: overrun on the last ROM word, whose write is dropped.
    clear_rom();
    rom[0] = 32'h4000_3FFF;
    rom[1] = 32'h0000_0000;
    for (int i = 2; i < 8192; i++) rom[i] = 32'h5A5A_0000 ^ 32'(i);
    for (int i = 2; i < 8191; i++) expect_wr(32'(4 * (i - 2)), 32'h5A5A_0000 ^ 32'(i));
    pulse_start();
    wait_for(1, 9000, 1'b0);
    check("t5_flags", {29'd0, busy, done, err}, 32'b001);
    check("t5_wr_valid", {31'd0, wr_valid}, 32'd0);
    check("t5_rom_addr", {16'd0, rom_addr}, 32'd0);
    repeat (3) @(negedge clk);
    check("final_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/simdma_init_loader.md
# simdma_init_loader

Sequencer that reads the 32-bit simdma init ROM (8K words, synchronous read, 1-cycle latency, no read enable) and turns its record stream into 32-bit memory writes on a valid/ready interface. Sits between the init ROM and the simdma write port. It runs once per `start` to preload target memory before simulation begins.

## Interface
- `ROM_WORDS`, 8192: ROM depth in words; the last legal address is `ROM_WORDS-1`.
- `gclk`  in  iu_clk_type  clock; all logic on `gclk.clk`
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  single-cycle pulse; begins a load from ROM word 0
- `rom_addr`  out  16  ROM word address, combinational from next-pointer
- `rom_dout`  in  32  ROM data for the address sampled at the previous edge
- `wr_valid`  out  1  write request valid
- `wr_ready`  in  1  write accepted when `wr_valid & wr_ready`
- `wr_addr`  out  32  write byte address (word aligned)
- `wr_data`  out  32  write data
- `busy`  out  1  load in progress
- `done`  out  1  level; END record reached and all writes accepted
- `err`  out  1  level; load aborted

## Operation
- Record format:
  - header word: op = [31:30], count = [13:0]; bits [29:14] are ignored.
  - The header is followed by a destination word. A destination with [1:0] ≠ 0 is an error.
  - Ops:
    - 00 END: no further words.
    - 01 WRITE: `count` data words follow.
    - 10 FILL: one data word follows and is written `count` times.
    - 11: error.
- States: IDLE, HDR, DST, DATA, FILL, DRAIN, DONE, ERR.
- IDLE/DONE/ERR:
  - `rom_addr` = 0.
  - `start` → HDR, `ptr` = 0, clears `done`/`err`.
  - `start` is ignored in all other states.
- HDR: capture the header.
  - END → DRAIN.
  - op 11 → ERR.
  - otherwise → DST.
- DST: load the write-address counter.
  - Misaligned destination → ERR.
  - count = 0 → HDR (record skipped, zero writes).
  - otherwise → DATA or FILL.
- DATA: each captured word loads the output register. Address advances +4 and count decrements. Last word → HDR.
- FILL: the data word is captured once and `ptr` advances past it. Writes repeat with no ROM reads until count is exhausted, then → HDR.
- DRAIN: wait until the output register is empty, then → DONE.
- Pointer and ROM:
  - `ptr` advances by one per consumed ROM word. `rom_addr` = `ptr_next`, so the ROM samples the next address on the same edge that `ptr` updates.
  - On a stall, `rom_addr` holds `ptr`, the ROM re-reads the same word, and `rom_dout` stays valid.
- Overrun: consuming word `ROM_WORDS-1` while still needing more words → ERR.
- Output register:
  - Loads when empty or when `wr_ready` is high.
  - `wr_addr`/`wr_data` are stable while `wr_valid & !wr_ready`.
  - `wr_addr` wraps modulo 2^32.
- ERR: `wr_valid` drops immediately, and any pending write is discarded.

## Timing
- Reset values: `rom_addr` 0, `wr_valid` 0, `wr_addr` 0, `wr_data` 0, `busy` 0, `done` 0, `err` 0, state IDLE. Reset mid-load aborts with no further writes.
- Edge E0 samples `start`: the ROM samples address 0 and `busy` rises after E0.
  - E1: header captured.
  - E2: destination captured.
  - E3: first data word captured; `wr_valid` is high after E3.
- Throughput is 1 write/cycle with `wr_ready` = 1 in both DATA and FILL.
- Record switch costs 2 cycles (HDR + DST) with no write bubble beyond them.
- `done` rises the cycle after the last write handshake following END, together with `busy` falling.
- `err` rises on the edge that detects the fault, together with `busy` falling.

## Structure
- The op encoding enum (END/WRITE/FILL/RSVD), header field positions, and the `ROM_WORDS` default go into `libiu`.
- Single module with no sub-module. The output register is inline.

## Test plan
- ROM = {WRITE cnt 3, dst 0x1000, A,B,C, END}, `wr_ready` = 1 → writes (0x1000,A), (0x1004,B), (0x1008,C) on 3 consecutive cycles; first `wr_valid` 3 cycles after `start`; `done` = 1.
- FILL cnt 4, dst 0x2000, data 0xDEADBEEF, END → 4 writes at 0x2000–0x200C all 0xDEADBEEF; `rom_addr` is not re-read during the repeats.
- WRITE cnt 8 with `wr_ready` toggling 1010… → 8 writes in order; data and address stay stable across stalls; no word lost or duplicated.
- Header op 11, or dst 0x1002 → `err` = 1, `busy` = 0, `wr_valid` = 0, no write issued; a new `start` clears `err` and restarts from word 0.
- ROM image with no END → `err` after `ptr` reaches 8191.
- `rst` low mid-DATA → all outputs 0 asynchronously; a `start` pulse while busy is ignored.
- count = 0 record followed by WRITE cnt 1 → exactly one write.
